imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0007_8000, meaning the instruction returned for unloaded or blocked fetches.
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock; all logic rises on posedge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse that begins a program load.
- load_len  input  7  number of words to load, 0..64; sampled on load_start.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data, most-significant byte of each word first.
- in_ready  output  1  block accepts a byte this cycle.
- busy  output  1  a load is in progress.
- load_done  output  1  one-cycle pulse when the load completes.
- words_loaded  output  7  count of words committed in the current or last load.
- fetch_addr  input  6  word address to fetch.
- instr  output  32  fetched instruction, registered.
- instr_valid  output  1  instr is a real fetch result.

Function
REQ-004 The block SHALL implement a 3-state FSM with states IDLE, LOAD and RUN; reset SHALL enter IDLE.
REQ-005 load_start in any state SHALL move the FSM to LOAD, capture load_len, clear words_loaded, the byte counter and all per-word valid bits, and discard any partial word.
REQ-006 If load_start arrives with load_len==0, the FSM SHALL go directly to RUN and pulse load_done on the next cycle with words_loaded=0.
REQ-007 in_ready SHALL be 1 only in LOAD; a byte SHALL be accepted exactly when in_valid&&in_ready.
REQ-008 Bytes SHALL assemble big-endian: byte0 goes to bits [31:24] and byte3 to bits [7:0].
REQ-009 On the 4th accepted byte, the word SHALL be written to mem[words_loaded], that word's valid bit SHALL be set, and words_loaded SHALL increment, all in the same cycle.
REQ-010 When words_loaded reaches the captured length, the FSM SHALL enter RUN on the next cycle, pulse load_done for exactly one cycle, and drop in_ready in that same cycle.
REQ-011 load_len values greater than DEPTH SHALL be clamped to DEPTH.
REQ-012 The write address SHALL never wrap.
REQ-013 busy SHALL equal (state==LOAD).
REQ-014 Fetch SHALL have 1-cycle latency: instr and instr_valid SHALL reflect the fetch_addr sampled on the previous posedge.
REQ-015 In RUN, instr SHALL be mem[fetch_addr] if that word's valid bit is set, else NOP_WORD; instr_valid SHALL be 1.
REQ-016 In IDLE or LOAD, instr SHALL be NOP_WORD and instr_valid SHALL be 0.
REQ-017 If load_start and an accepted byte coincide, load_start SHALL win and the byte SHALL be dropped.
REQ-018 Memory contents SHALL be retained across load_start; only the valid bits are cleared.

Reset
REQ-019 On rst, the FSM SHALL go to IDLE.
REQ-020 On rst, in_ready, busy, load_done and instr_valid SHALL be 0, words_loaded and the byte counter SHALL be 0, all valid bits SHALL be cleared, and instr SHALL be NOP_WORD.
REQ-021 Reset mid-load SHALL abandon the load without a load_done pulse.
REQ-022 Memory array contents SHALL NOT be reset.

Structure
REQ-023 The package imem_pkg SHALL hold: the state enum type (IDLE/LOAD/RUN), NOP_WORD, DEPTH, and the address width localparam (6).
REQ-024 The memory array with its write port and registered read port SHALL be one sub-module, imem_ram (64x32, 1 write port, 1 synchronous read port).
REQ-025 The FSM, byte assembler and valid-bit vector SHALL reside in imem_loader.

Verification
REQ-026 Reset check: assert rst for 2 cycles -> IDLE, in_ready=0, instr=32'h00078000, instr_valid=0.
REQ-027 Basic load: load_len=2, send bytes 80,08,00,01,82,10,00,01 with in_valid held high -> load_done pulses 1 cycle after the 8th byte, words_loaded=2; then fetch addr 1 -> instr=32'h82100001, valid=1, next cycle.
REQ-028 Unloaded fetch: after the basic load, fetch addr 5 -> instr=32'h00078000, instr_valid=1.
REQ-029 Backpressure and gaps: insert random in_valid gaps -> the same words are written, there is no byte loss, and in_ready stays 1 throughout LOAD.
REQ-030 Abort: during a load_len=3 load, after 5 bytes, issue load_start with load_len=1 -> the partial word is dropped, words_loaded=0, all valid bits are cleared, and the next 4 bytes form word 0.
REQ-031 Edge cases:
- load_len=0 -> load_done the next cycle, and all fetches return NOP.
- load_len=100 -> clamped; done after 256 bytes with words_loaded=64.
- rst asserted mid-load -> no load_done pulse.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
//   state_t   : loader FSM states (IDLE / LOAD / RUN)
//   DEPTH     : number of 32-bit instruction words
//   AW        : word address width
//   LEN_W     : width of load length / word count fields
//   NOP_WORD  : instruction returned for unloaded or blocked fetches
package imem_pkg;

  localparam int          DEPTH    = 64;
  localparam int          AW       = 6;
  localparam int          LEN_W    = 7;
  localparam logic [31:0] NOP_WORD = 32'h0007_8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: load control, byte stream and fetch port of the loader.
//   master : drives load_start/load_len, in_valid/in_data, fetch_addr
//   slave  : drives in_ready, busy, load_done, words_loaded, instr, instr_valid
interface imem_loader_if;
  import imem_pkg::*;

  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             busy;
  logic             load_done;
  logic [LEN_W-1:0] words_loaded;
  logic [AW-1:0]    fetch_addr;
  logic [31:0]      instr;
  logic             instr_valid;

  modport master (
    output load_start, load_len, in_valid, in_data, fetch_addr,
    input  in_ready, busy, load_done, words_loaded, instr, instr_valid
  );

  modport slave (
    input  load_start, load_len, in_valid, in_data, fetch_addr,
    output in_ready, busy, load_done, words_loaded, instr, instr_valid
  );

endinterface

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x 32 instruction memory, one write port and one
// synchronous read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : read word address (sampled on posedge)
//   rdata : read data, valid the cycle after raddr is sampled
module imem_ram #(
  parameter int DEPTH = imem_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [imem_pkg::AW-1:0] waddr,
  input  logic [31:0]            wdata,
  input  logic [imem_pkg::AW-1:0] raddr,
  output logic [31:0]            rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program from a big-endian byte stream into the
// instruction memory, then serves 1-cycle-latency instruction fetches.
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem_loader_if.slave
//              load_start/load_len begin a load (len clamped to DEPTH)
//              in_valid/in_data/in_ready byte stream, MSB of word first
//              busy, load_done, words_loaded report load progress
//              fetch_addr -> instr/instr_valid one cycle later
//
// state | meaning
// IDLE  | after reset, no program loaded; fetches return NOP, not valid
// LOAD  | accepting bytes, assembling and committing words
// RUN   | load complete; fetches return loaded words (NOP if unloaded)
module imem_loader #(
  parameter int          DEPTH    = imem_pkg::DEPTH,
  parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);
  import imem_pkg::state_t;
  import imem_pkg::IDLE;
  import imem_pkg::LOAD;
  import imem_pkg::RUN;
  import imem_pkg::AW;
  import imem_pkg::LEN_W;

  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  state_t           state, state_nx;
  logic             done_nx;
  logic             done_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] words_q;
  logic [1:0]       byte_cnt;
  logic [23:0]      byte_buf;
  logic [DEPTH-1:0] vbits;
  logic             run_q;
  logic             hit_q;
  logic [31:0]      rd_data;

  logic [LEN_W-1:0] len_clamped;
  logic             accept;
  logic             word_done;
  logic             wr_en;
  logic             last_word;

  assign len_clamped = (bus.load_len > DEPTH_LEN) ? DEPTH_LEN : bus.load_len;

  // A load_start in the same cycle as a byte drops that byte.
  assign accept    = bus.in_valid && (state == LOAD) && !bus.load_start;
  assign word_done = accept && (byte_cnt == 2'd3);
  // Length is clamped, so this guard only keeps the write address from wrapping.
  assign wr_en     = word_done && (words_q < DEPTH_LEN);
  assign last_word = word_done && ((words_q + 7'd1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        // Leave LOAD on the edge that commits the final word so in_ready
        // drops together with the load_done pulse.
        if (last_word) begin
          state_nx = RUN;
          done_nx  = 1'b1;
        end
      end
      RUN: ;
      default: state_nx = IDLE;
    endcase
    if (bus.load_start) begin
      state_nx = (len_clamped == '0) ? RUN : LOAD;
      done_nx  = (len_clamped == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      len_q    <= '0;
      words_q  <= '0;
      byte_cnt <= '0;
      byte_buf <= '0;
      vbits    <= '0;
      run_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      done_q <= done_nx;
      run_q  <= (state == RUN);
      hit_q  <= vbits[bus.fetch_addr];
      if (bus.load_start) begin
        len_q    <= len_clamped;
        words_q  <= '0;
        byte_cnt <= '0;
        vbits    <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        byte_buf <= {byte_buf[15:0], bus.in_data};
        if (wr_en) begin
          vbits[words_q[AW-1:0]] <= 1'b1;
          words_q                <= words_q + 7'd1;
        end
      end
    end
  end

  imem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (words_q[AW-1:0]),
    .wdata ({byte_buf, bus.in_data}),
    .raddr (bus.fetch_addr),
    .rdata (rd_data)
  );

  assign bus.in_ready     = (state == LOAD);
  assign bus.busy         = (state == LOAD);
  assign bus.load_done    = done_q;
  assign bus.words_loaded = words_q;
  // run_q/hit_q are registered alongside the RAM read, so the mux sees a
  // consistent view of the previous-cycle fetch.
  assign bus.instr        = (run_q && hit_q) ? rd_data : NOP_WORD;
  assign bus.instr_valid  = run_q;

endmodule
